// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: program counter, IF/ID pipeline register and fetch-control FSM.
// The PC advances by 4 each cycle unless held by hazard detection or retargeted by
// a redirect resolved in ID. A redirect also flushes IF/ID with a bubble.
// A hold (PC_write_i=0) dominates a redirect; ID re-issues the redirect next cycle.
// Optional feature macro: IFID_STALL_COUNT_EN adds a saturating 16-bit stall-cycle
// counter on stall_count_o; without it stall_count_o is tied to 0.
module if_id_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_write_i,
   input  logic        IFID_write_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_IFID_o,
   output logic [31:0] pc_plus4_IFID_o,
   output logic        valid_IFID_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_count_o
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_next_seq;
   logic [31:0] instr_q;
   logic [31:0] pc_plus4_q;
   logic        valid_q;
   logic        take_redirect;

   // Sequential fetch address; the 32-bit add wraps naturally at 2^32.
   assign pc_next_seq   = pc_q + 32'd4;
   // A redirect only takes effect when the PC is allowed to move.
   assign take_redirect = redirect_i & PC_write_i;

   // Next-state logic: stall has top priority, then flush on redirect, else fetch.
   always_comb begin
      state_d = FETCH;
      if (!PC_write_i) begin
         state_d = STALL;
      end else if (redirect_i) begin
         state_d = FLUSH;
      end
   end

   // Next PC: hold, redirect target (word aligned), or sequential.
   always_comb begin
      pc_d = pc_next_seq;
      if (!PC_write_i) begin
         pc_d = pc_q;
      end else if (redirect_i) begin
         pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // IF/ID register: hold, flush to a bubble, or capture the fetched word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_q    <= NOP_WORD;
         pc_plus4_q <= 32'd0;
         valid_q    <= 1'b0;
      end else if (IFID_write_i) begin
         if (take_redirect) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
         end else begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_next_seq;
            valid_q    <= 1'b1;
         end
      end
   end

`ifdef IFID_STALL_COUNT_EN
   logic [15:0] stall_count_q;

   // Stall-cycle counter: counts cycles with PC held, saturating at all ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_count_q <= 16'd0;
      end else if (!PC_write_i && (stall_count_q != 16'hFFFF)) begin
         stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign stall_count_o = stall_count_q;
`else
   assign stall_count_o = 16'd0;
`endif

   assign pc_o            = pc_q;
   assign instr_IFID_o    = instr_q;
   assign pc_plus4_IFID_o = pc_plus4_q;
   assign valid_IFID_o    = valid_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: directed bench for if_id_fetch_stage with a behavioural
// model feeding an expected-output queue, a per-cycle compare process, and
// hand-computed literal checks at key points.
module tb_if_id_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam int W = 115;

   logic        clk;
   logic        reset;
   logic        PC_write_i;
   logic        IFID_write_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_i;
   logic [31:0] pc_o;
   logic [31:0] instr_IFID_o;
   logic [31:0] pc_plus4_IFID_o;
   logic        valid_IFID_o;
   logic [1:0]  state_o;
   logic [15:0] stall_count_o;

   int total;
   int bad;

   logic [W-1:0] exp_q[$];

   if_id_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
      .clk(clk),
      .reset(reset),
      .PC_write_i(PC_write_i),
      .IFID_write_i(IFID_write_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .instr_i(instr_i),
      .pc_o(pc_o),
      .instr_IFID_o(instr_IFID_o),
      .pc_plus4_IFID_o(pc_plus4_IFID_o),
      .valid_IFID_o(valid_IFID_o),
      .state_o(state_o),
      .stall_count_o(stall_count_o)
   );

   // Instruction memory contents: a word derived from its address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign instr_i = instr_of(pc_o);

   // Clock and reset block.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model.
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid;
   logic [1:0]  m_state;
   logic [15:0] m_cnt;
   bit          m_known = 1'b0;

   always @(posedge clk) begin
      logic [31:0] old_pc;
      if (!reset) begin
         m_pc = RESET_PC; m_instr = NOP_WORD; m_pp4 = 32'd0;
         m_valid = 1'b0; m_state = 2'd0; m_cnt = 16'd0;
         m_known = 1'b1;
      end else if (m_known) begin
         old_pc = m_pc;
         if (!PC_write_i)     m_pc = old_pc;
         else if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
         else                 m_pc = old_pc + 32'd4;
         if (IFID_write_i) begin
            if (redirect_i && PC_write_i) begin
               m_instr = NOP_WORD; m_valid = 1'b0;
            end else begin
               m_instr = instr_of(old_pc); m_pp4 = old_pc + 32'd4; m_valid = 1'b1;
            end
         end
         m_state = !PC_write_i ? 2'd1 : (redirect_i ? 2'd2 : 2'd0);
`ifdef IFID_STALL_COUNT_EN
         if (!PC_write_i && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`else
         m_cnt = 16'd0;
`endif
      end
      if (m_known) exp_q.push_back({m_pc, m_instr, m_pp4, m_valid, m_state, m_cnt});
   end

   // Scoreboard compare: every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pc_o, instr_IFID_o, pc_plus4_IFID_o, valid_IFID_o, state_o, stall_count_o};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, a, e);
         end
      end
   end

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Driver: apply one cycle of inputs, advance past the edge to the sampling point.
   task automatic step(input bit rst, input bit pw, input bit iw, input bit rd,
                       input logic [31:0] rpc);
      reset = rst; PC_write_i = pw; IFID_write_i = iw;
      redirect_i = rd; redirect_pc_i = rpc;
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [15:0] CNT_EN = 
`ifdef IFID_STALL_COUNT_EN
      16'd1;
`else
      16'd0;
`endif

   initial begin
      total = 0;
      bad   = 0;
      // Reset.
      step(0, 1, 1, 0, 32'h0);
      step(0, 0, 0, 1, 32'h1234_5678);
      check_lit("rst_pc",    pc_o, 32'h0040_0000);
      check_lit("rst_instr", instr_IFID_o, NOP_WORD);
      check_lit("rst_pp4",   pc_plus4_IFID_o, 32'h0);
      check_lit("rst_valid", {31'd0, valid_IFID_o}, 32'd0);
      check_lit("rst_state", {30'd0, state_o}, 32'd0);
      check_lit("rst_cnt",   {16'd0, stall_count_o}, 32'd0);
      // Free run.
      step(1, 1, 1, 0, 32'h0);
      check_lit("run1_pc",    pc_o, 32'h0040_0004);
      check_lit("run1_instr", instr_IFID_o, 32'h0000_FFFF);
      check_lit("run1_valid", {31'd0, valid_IFID_o}, 32'd1);
      step(1, 1, 1, 0, 32'h0);
      check_lit("run2_pc",  pc_o, 32'h0040_0008);
      check_lit("run2_pp4", pc_plus4_IFID_o, 32'h0040_0008);
      // Two-cycle stall at 0x00400008.
      step(1, 0, 0, 0, 32'h0);
      step(1, 0, 0, 0, 32'h0);
      check_lit("stall_pc",    pc_o, 32'h0040_0008);
      check_lit("stall_instr", instr_IFID_o, 32'h0004_FFFB);
      check_lit("stall_state", {30'd0, state_o}, 32'd1);
      check_lit("stall_cnt",   {16'd0, stall_count_o}, {16'd0, 16'd2 * CNT_EN});
      // Redirect during stall is ignored.
      step(1, 0, 0, 1, 32'h0040_0100);
      check_lit("stallrd_pc",    pc_o, 32'h0040_0008);
      check_lit("stallrd_state", {30'd0, state_o}, 32'd1);
      // Redirect unstalled.
      step(1, 1, 1, 1, 32'h0040_0100);
      check_lit("rd_pc",    pc_o, 32'h0040_0100);
      check_lit("rd_instr", instr_IFID_o, NOP_WORD);
      check_lit("rd_valid", {31'd0, valid_IFID_o}, 32'd0);
      check_lit("rd_pp4",   pc_plus4_IFID_o, 32'h0040_0008);
      check_lit("rd_state", {30'd0, state_o}, 32'd2);
      // Back-to-back redirect with misaligned target.
      step(1, 1, 1, 1, 32'h0040_0203);
      check_lit("rd2_pc",    pc_o, 32'h0040_0200);
      check_lit("rd2_state", {30'd0, state_o}, 32'd2);
      step(1, 1, 1, 0, 32'h0);
      check_lit("after_rd_pc",    pc_o, 32'h0040_0204);
      check_lit("after_rd_valid", {31'd0, valid_IFID_o}, 32'd1);
      check_lit("after_rd_state", {30'd0, state_o}, 32'd0);
      // Wrap at top of address space.
      step(1, 1, 1, 1, 32'hFFFF_FFFC);
      step(1, 1, 1, 0, 32'h0);
      check_lit("wrap_pc",  pc_o, 32'h0000_0000);
      check_lit("wrap_pp4", pc_plus4_IFID_o, 32'h0000_0000);
      // PC held while IF/ID loads, then PC moves while IF/ID holds.
      step(1, 0, 1, 0, 32'h0);
      check_lit("pchold_pc",    pc_o, 32'h0000_0000);
      check_lit("pchold_instr", instr_IFID_o, 32'h0000_FFFF);
      step(1, 1, 0, 0, 32'h0);
      check_lit("ifidhold_pc",  pc_o, 32'h0000_0004);
      check_lit("ifidhold_pp4", pc_plus4_IFID_o, 32'h0000_0004);
      // Reset mid-stall with counter at 5.
      step(0, 1, 1, 0, 32'h0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0);
      check_lit("cnt5", {16'd0, stall_count_o}, {16'd0, 16'd5 * CNT_EN});
      step(0, 0, 0, 1, 32'h0040_0100);
      check_lit("rst2_pc",    pc_o, 32'h0040_0000);
      check_lit("rst2_state", {30'd0, state_o}, 32'd0);
      check_lit("rst2_cnt",   {16'd0, stall_count_o}, 32'd0);
      check_lit("rst2_valid", {31'd0, valid_IFID_o}, 32'd0);
      step(1, 1, 1, 0, 32'h0);
      check_lit("post_rst_instr", instr_IFID_o, 32'h0000_FFFF);
      step(1, 1, 1, 0, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
